// File: rtl/game_frame_scheduler_if.sv
// Bundles the engine handshake, game-over status and debug signals of the
// frame scheduler. The controller side (key listener / engines) uses master,
// the scheduler itself uses slave.
interface game_frame_scheduler_if;
  // Handshake semantics: start is a one-cycle request, taken only in IDLE or OVER.
  // logic_done_cycle is sampled only while logic_en is high; render_done only
  // while render_en is high. Holding an enable high is the scheduler's "ready",
  // and the matching done is the engine's "valid". The pass completes on the
  // first clock edge where both are high.
  logic        start;
  logic        logic_done_cycle;
  logic        render_done;
  logic        won_flag;
  logic        lost_flag;
  logic        logic_en;
  logic        render_en;
  logic        game_over;
  logic        won_latched;
  logic        timeout_err;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic [2:0]  state;

  modport master (
    output start, logic_done_cycle, render_done, won_flag, lost_flag,
    input  logic_en, render_en, game_over, won_latched, timeout_err,
           frame_count, overrun_count, state
  );

  modport slave (
    input  start, logic_done_cycle, render_done, won_flag, lost_flag,
    output logic_en, render_en, game_over, won_latched, timeout_err,
           frame_count, overrun_count, state
  );
endinterface

// File: rtl/game_frame_scheduler.sv
// Frame sequencer for the piano-tiles game: one logic pass then one render
// pass per frame tick, with overrun counting, game-over latching and an
// engine-hang watchdog that traps into a terminal FAULT state.
module game_frame_scheduler #(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int TMR_W          = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  game_frame_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_LOGIC  = 3'd2,
    S_RENDER = 3'd3,
    S_OVER   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [TMR_W-1:0] TICK_VAL = TMR_W'(FRAME_CYCLES - 1);
  localparam logic [TMR_W-1:0] WD_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   wd;
  logic               pending;
  logic               end_flag;
  logic               won_hold;
  logic [15:0]        frame_count_q;
  logic [7:0]         overrun_q;

  logic               counting;
  logic               tick;
  logic               restart;
  logic               engine_busy;

  // The timer only runs while a game is in progress; FAULT freezes it.
  assign counting    = (state_q == S_WAIT) || (state_q == S_LOGIC) || (state_q == S_RENDER);
  assign tick        = counting && (timer == TICK_VAL);
  assign engine_busy = (state_q == S_LOGIC) || (state_q == S_RENDER);
  assign restart     = ((state_q == S_IDLE) || (state_q == S_OVER)) && bus.start;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; an engine finishing beats a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_WAIT;
      S_WAIT:   if (pending || tick) state_d = S_LOGIC;
      S_LOGIC: begin
        if (bus.logic_done_cycle) state_d = S_RENDER;
        else if (wd == WD_LIMIT)  state_d = S_FAULT;
      end
      S_RENDER: begin
        if (bus.render_done)     state_d = end_flag ? S_OVER : S_WAIT;
        else if (wd == WD_LIMIT) state_d = S_FAULT;
      end
      S_OVER:   if (bus.start) state_d = S_WAIT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    bus.logic_en      = (state_q == S_LOGIC);
    bus.render_en     = (state_q == S_RENDER);
    bus.game_over     = (state_q == S_OVER);
    bus.timeout_err   = (state_q == S_FAULT);
    bus.won_latched   = (state_q == S_OVER) && won_hold;
    bus.frame_count   = frame_count_q;
    bus.overrun_count = overrun_q;
    bus.state         = state_q;
  end

  // Frame timer: held at 0 between games, wraps every FRAME_CYCLES while playing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        timer <= '0;
    else if (restart)                                 timer <= '0;
    else if ((state_q == S_IDLE) || (state_q == S_OVER)) timer <= '0;
    else if (counting) begin
      if (tick) timer <= '0;
      else      timer <= timer + 1'b1;
    end
  end

  // Watchdog: restarts on every state change, runs only while an engine owns the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wd <= '0;
    else if (state_d != state_q) wd <= '0;
    else if (engine_busy)        wd <= wd + 1'b1;
  end

  // Pending tick: forces the first frame at start, and remembers ticks that land mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          pending <= 1'b0;
    else if (restart)                   pending <= 1'b1;
    else if (state_q == S_WAIT)         pending <= pending && tick;
    else if (engine_busy && tick)       pending <= 1'b1;
  end

  // Overrun counter: a tick that finds one already pending is a lost frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overrun_q <= '0;
    else if (restart) overrun_q <= '0;
    else if (engine_busy && tick && pending && (overrun_q != 8'hFF))
      overrun_q <= overrun_q + 8'd1;
  end

  // Game result captured when the logic pass completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_flag <= 1'b0;
      won_hold <= 1'b0;
    end else if (restart) begin
      end_flag <= 1'b0;
      won_hold <= 1'b0;
    end else if ((state_q == S_LOGIC) && bus.logic_done_cycle) begin
      end_flag <= bus.won_flag || bus.lost_flag;
      won_hold <= bus.won_flag;
    end
  end

  // Frame counter: one frame completes on each finished render pass; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        frame_count_q <= '0;
    else if (restart) frame_count_q <= '0;
    else if ((state_q == S_RENDER) && bus.render_done)
      frame_count_q <= frame_count_q + 16'd1;
  end

endmodule
